// File: rtl/fifo_rr_drain_sched_pkg.sv
// fifo_sched_pkg: shared state encoding for the round-robin fifo drain scheduler
package fifo_sched_pkg;
    typedef enum logic {ST_IDLE = 1'b0, ST_BURST = 1'b1} state_t;
endpackage

// File: rtl/fifo_rr_drain_sched_if.sv
// fifo_rr_drain_sched_if: source-fifo side and consumer stream side of the drain scheduler
interface fifo_rr_drain_sched_if #(
    parameter int N_SRC      = 4,
    parameter int DATA_WIDTH = 8
);
    localparam int IDX_W = $clog2(N_SRC);
    logic [N_SRC-1:0]            src_en_i;
    logic [N_SRC-1:0]            fifo_empty_i;
    logic [N_SRC*DATA_WIDTH-1:0] fifo_data_i;
    logic [N_SRC-1:0]            fifo_rd_o;
    logic                        m_valid_o;
    logic [DATA_WIDTH-1:0]       m_data_o;
    logic [IDX_W-1:0]            m_src_o;
    logic                        m_ready_i;
    logic                        busy_o;
    modport master (
        input  src_en_i, fifo_empty_i, fifo_data_i, m_ready_i,
        output fifo_rd_o, m_valid_o, m_data_o, m_src_o, busy_o
    );
    modport slave (
        output src_en_i, fifo_empty_i, fifo_data_i, m_ready_i,
        input  fifo_rd_o, m_valid_o, m_data_o, m_src_o, busy_o
    );
endinterface

// File: rtl/fifo_rr_drain_sched_rr_pick.sv
// rr_pick: combinational rotate-priority search, first set req bit at or after ptr
module rr_pick #(
    parameter  int N_SRC = 4,
    localparam int IDX_W = $clog2(N_SRC)
) (
    input  logic [N_SRC-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic             any,
    output logic [IDX_W-1:0] idx
);
    // Scan farthest offset first so the closest requester to ptr wins last
    always_comb begin
        any = |req;
        idx = '0;
        for (int i = N_SRC - 1; i >= 0; i--)
            if (req[(int'(ptr) + i) % N_SRC]) idx = IDX_W'((int'(ptr) + i) % N_SRC);
    end
endmodule

// File: rtl/fifo_rr_drain_sched.sv
// fifo_rr_drain_sched: round-robin burst drain of N show-ahead fifos into one registered stream
module fifo_rr_drain_sched
    import fifo_sched_pkg::*;
#(
    parameter  int N_SRC      = 4,
    parameter  int DATA_WIDTH = 8,
    parameter  int MAX_BURST  = 4,
    localparam int IDX_W      = $clog2(N_SRC),
    localparam int CNT_W      = $clog2(MAX_BURST + 1)
) (
    input logic                  clk,
    input logic                  rst_n,
    fifo_rr_drain_sched_if.master bus
);
    state_t           state, state_d;
    logic [IDX_W-1:0] grant, rr_ptr, pick_idx;
    logic [CNT_W-1:0] burst_cnt;
    logic [N_SRC-1:0] eligible;
    logic             pick_any, slot_free, pop, leave;

    rr_pick #(.N_SRC(N_SRC)) u_pick (
        .req(eligible),
        .ptr(rr_ptr),
        .any(pick_any),
        .idx(pick_idx)
    );

    // Pop is gated by reset so an in-flight burst never consumes a word it will discard
    always_comb begin
        eligible      = bus.src_en_i & ~bus.fifo_empty_i;
        slot_free     = !bus.m_valid_o || bus.m_ready_i;
        pop           = rst_n && state == ST_BURST && eligible[grant] && slot_free;
        leave         = state == ST_BURST && (!eligible[grant] || (pop && burst_cnt == CNT_W'(MAX_BURST - 1)));
        state_d       = state == ST_IDLE ? (pick_any ? ST_BURST : ST_IDLE) : (leave ? ST_IDLE : ST_BURST);
        bus.fifo_rd_o = N_SRC'(pop) << grant;
        bus.busy_o    = state == ST_BURST;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            grant         <= '0;
            rr_ptr        <= '0;
            burst_cnt     <= '0;
            bus.m_valid_o <= 1'b0;
            bus.m_data_o  <= '0;
            bus.m_src_o   <= '0;
        end else begin
            state <= state_d;
            if (state == ST_IDLE && pick_any) begin
                grant     <= pick_idx;
                burst_cnt <= '0;
            end
            if (pop) burst_cnt <= burst_cnt + CNT_W'(1);
            if (leave) rr_ptr <= grant == IDX_W'(N_SRC - 1) ? '0 : grant + IDX_W'(1);
            if (pop) begin
                bus.m_valid_o <= 1'b1;
                bus.m_data_o  <= bus.fifo_data_i[int'(grant) * DATA_WIDTH +: DATA_WIDTH];
                bus.m_src_o   <= grant;
            end else if (slot_free) begin
                bus.m_valid_o <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fifo_rr_drain_sched.sv
// tb_fifo_rr_drain_sched: scoreboard bench with behavioural show-ahead fifos per source
module tb_fifo_rr_drain_sched;
    localparam int N = 4;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    fifo_rr_drain_sched_if #(.N_SRC(N), .DATA_WIDTH(8)) bus();
    fifo_rr_drain_sched #(.N_SRC(N), .DATA_WIDTH(8), .MAX_BURST(4)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );
    always #5 clk = ~clk;

    logic [7:0] mem [N][32];
    int         wr_p [N];
    int         rd_p [N];
    logic [N-1:0] pend = '0;
    logic [9:0] exp_q [$];
    logic [9:0] acc_w [$];
    int         acc_cyc [$];
    int         cyc = 0;
    int         n_chk = 0;
    int         n_err = 0;
    bit         sb_on = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h @cyc %0d", tag, got, exp, cyc);
        end
    endtask

    task automatic push(input int k, input logic [7:0] d);
        mem[k][wr_p[k] % 32] = d;
        wr_p[k]++;
    endtask

    task automatic expect_w(input int k, input logic [7:0] d);
        exp_q.push_back({2'(k), d});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_acc(input int n, input int budget);
        int t = 0;
        while (acc_cyc.size() < n && t < budget) begin
            tick();
            t++;
        end
        chk("acc_timeout", acc_cyc.size() >= n, 1);
    endtask

    task automatic wait_idle(input int budget, input bit all_empty);
        int t = 0;
        while (t < budget && !(exp_q.size() == 0 && !bus.busy_o && !bus.m_valid_o &&
                               (!all_empty || &bus.fifo_empty_i))) begin
            tick();
            t++;
        end
        chk("idle_timeout", t < budget, 1);
    endtask

    // Show-ahead fifo model: head visible while non-empty, pop lands on the next edge
    always_comb begin
        for (int k = 0; k < N; k++) begin
            bus.fifo_empty_i[k]       = rd_p[k] == wr_p[k];
            bus.fifo_data_i[k*8 +: 8] = mem[k][rd_p[k] % 32];
        end
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int k = 0; k < N; k++)
            if (pend[k]) rd_p[k] <= rd_p[k] + 1;
    end

    always @(negedge clk) begin
        logic [9:0] e;
        pend <= bus.fifo_rd_o;
        if (rst_n) begin
            chk("rd_of_empty", bus.fifo_rd_o & bus.fifo_empty_i, 0);
            chk("rd_onehot", $onehot0(bus.fifo_rd_o), 1);
            if (bus.m_valid_o && bus.m_ready_i) begin
                acc_cyc.push_back(cyc);
                acc_w.push_back({bus.m_src_o, bus.m_data_o});
                if (sb_on) begin
                    if (exp_q.size() == 0) chk("unexpected_word", exp_q.size(), 1);
                    else begin
                        e = exp_q.pop_front();
                        chk("word", {bus.m_src_o, bus.m_data_o}, e);
                    end
                end
            end
        end
    end

    initial begin
        logic [7:0] held;
        bus.src_en_i  = '0;
        bus.m_ready_i = 1'b1;
        repeat (3) tick();
        chk("rst_valid", bus.m_valid_o, 0);
        chk("rst_data", bus.m_data_o, 0);
        chk("rst_src", bus.m_src_o, 0);
        chk("rst_rd", bus.fifo_rd_o, 0);
        chk("rst_busy", bus.busy_o, 0);
        rst_n = 1'b1;
        bus.src_en_i = '1;
        sb_on = 1'b1;

        // single source longer than one burst
        acc_cyc.delete();
        for (int i = 0; i < 6; i++) begin
            push(0, 8'(i));
            expect_w(0, 8'(i));
        end
        wait_idle(100, 1);
        chk("t1_count", acc_cyc.size(), 6);
        chk("t1_burst", acc_cyc[3] - acc_cyc[0], 3);
        chk("t1_bubble", acc_cyc[4] - acc_cyc[3], 2);

        // short sources, skip empties
        acc_cyc.delete();
        push(1, 8'h10);
        push(1, 8'h11);
        push(3, 8'h30);
        expect_w(1, 8'h10);
        expect_w(1, 8'h11);
        expect_w(3, 8'h30);
        wait_idle(100, 1);
        chk("t2_count", acc_cyc.size(), 3);
        chk("t2_busy", bus.busy_o, 0);

        // all sources loaded: rotation 0,1,2,3,0,... with wrap
        acc_cyc.delete();
        for (int k = 0; k < N; k++)
            for (int w = 0; w < 8; w++) push(k, 8'(8'h80 + k * 16 + w));
        for (int r = 0; r < 2; r++)
            for (int k = 0; k < N; k++)
                for (int w = 0; w < 4; w++) expect_w(k, 8'(8'h80 + k * 16 + r * 4 + w));
        wait_idle(300, 1);
        chk("t3_count", acc_cyc.size(), 32);
        chk("t3_rate", acc_cyc[4] - acc_cyc[0], 5);

        // backpressure mid-burst
        acc_cyc.delete();
        for (int i = 0; i < 6; i++) begin
            push(0, 8'(8'h60 + i));
            expect_w(0, 8'(8'h60 + i));
        end
        wait_acc(2, 50);
        bus.m_ready_i = 1'b0;
        held = bus.m_data_o;
        chk("t4_held", held, 8'h62);
        repeat (5) begin
            @(negedge clk);
            chk("t4_stall_rd", bus.fifo_rd_o, 0);
            chk("t4_stable", bus.m_data_o, held);
            chk("t4_valid", bus.m_valid_o, 1);
        end
        tick();
        bus.m_ready_i = 1'b1;
        wait_idle(100, 1);
        chk("t4_count", acc_cyc.size(), 6);

        // masked source and mid-burst disable
        acc_cyc.delete();
        bus.src_en_i = 4'b1011;
        for (int i = 0; i < 4; i++) push(2, 8'(8'hA0 + i));
        for (int i = 0; i < 8; i++) push(0, 8'(8'h40 + i));
        for (int i = 0; i < 3; i++) expect_w(0, 8'(8'h40 + i));
        wait_acc(2, 50);
        bus.src_en_i = 4'b1010;
        @(negedge clk);
        chk("t5_rd_off", bus.fifo_rd_o, 0);
        @(negedge clk);
        chk("t5_exit", bus.busy_o, 0);
        wait_idle(100, 0);
        chk("t5_src2_kept", wr_p[2] - rd_p[2], 4);
        chk("t5_src0_left", wr_p[0] - rd_p[0], 5);

        // reset mid-burst, restart from src0
        sb_on = 1'b0;
        acc_cyc.delete();
        bus.src_en_i = '1;
        wait_acc(1, 50);
        chk("t6_pre_busy", bus.busy_o, 1);
        rst_n = 1'b0;
        tick();
        chk("t6_valid", bus.m_valid_o, 0);
        chk("t6_rd", bus.fifo_rd_o, 0);
        chk("t6_busy", bus.busy_o, 0);
        rst_n = 1'b1;
        acc_cyc.delete();
        acc_w.delete();
        wait_acc(1, 50);
        chk("t6_src", acc_w[0][9:8], 0);
        chk("t6_data", acc_w[0][7:0], 8'h43);
        wait_idle(200, 1);
        chk("final_valid", bus.m_valid_o, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
